// File: rtl/cacheline_adapter.sv
// cacheline_adapter
//   Sits between the pipelined cache and banked memory. A single 256-bit
//   line transfer on the dfp side becomes a 4-beat, 64-bit burst on the
//   bmem side. One line read (fill) or line write (writeback) is in flight
//   at a time; completion is a one-cycle dfp_resp pulse.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   dfp_addr     line address from cache (offset bits ignored)
//   dfp_read     fill request, held until dfp_resp
//   dfp_write    writeback request, held until dfp_resp
//   dfp_wdata    writeback line
//   dfp_rdata    filled line, valid with dfp_resp after a read, held after
//   dfp_resp     one-cycle completion pulse
//   bmem_addr    burst base address (line aligned)
//   bmem_read    burst read request
//   bmem_write   write beat valid
//   bmem_wdata   current write beat
//   bmem_ready   memory accepts read request / write beat
//   bmem_rdata   read beat
//   bmem_rvalid  read beat valid
module cacheline_adapter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] line_fill;
  logic              last_beat;
  logic              unused_addr_bits;

  always_comb begin
    unused_addr_bits = ^dfp_addr[OFF_W-1:0];
  end

  always_comb begin
    last_beat = (cnt == CNT_W'(BEATS - 1));
  end

  // Line buffer with the incoming read beat merged into its slot.
  always_comb begin
    line_fill = line_q;
    line_fill[cnt*BEAT_W +: BEAT_W] = bmem_rdata;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dfp_read) begin
          state_nx = RD_REQ;
        end else if (dfp_write) begin
          state_nx = WR;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          state_nx = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bmem_rvalid && last_beat) begin
          state_nx = RESP;
        end
      end
      WR: begin
        if (bmem_ready && last_beat) begin
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath. line_q doubles as writeback source and fill assembly buffer;
  // the completed fill is copied into rdata_q so dfp_rdata never shows a
  // partially assembled line and survives later writebacks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dfp_read) begin
            addr_q <= {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
          end else if (dfp_write) begin
            addr_q <= {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
            line_q <= dfp_wdata;
          end
        end
        RD_REQ: begin
          cnt <= '0;
        end
        RD_DATA: begin
          if (bmem_rvalid) begin
            line_q <= line_fill;
            cnt    <= cnt + CNT_W'(1);
            if (last_beat) begin
              rdata_q <= line_fill;
            end
          end
        end
        WR: begin
          if (bmem_ready) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    dfp_rdata  = rdata_q;
    dfp_resp   = 1'b0;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    case (state)
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      WR: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = line_q[cnt*BEAT_W +: BEAT_W];
      end
      RESP: begin
        dfp_resp = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
module tb_cacheline_adapter;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = LW / BW;

  logic          clk;
  logic          rst;
  logic [31:0]   dfp_addr;
  logic          dfp_read;
  logic          dfp_write;
  logic [LW-1:0] dfp_wdata;
  logic [LW-1:0] dfp_rdata;
  logic          dfp_resp;
  logic [31:0]   bmem_addr;
  logic          bmem_read;
  logic          bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic          bmem_ready;
  logic [BW-1:0] bmem_rdata;
  logic          bmem_rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  cacheline_adapter #(.LINE_W(LW), .BEAT_W(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: one outstanding line job, tracked as
  // "request issued yet" plus number of beats moved so far.
  bit          m_rd = 0;
  bit          m_wr = 0;
  bit          m_req_done = 0;
  bit          m_resp = 0;
  int          m_nb = 0;
  bit [31:0]   m_addr = '0;
  bit [LW-1:0] m_line = '0;
  bit [LW-1:0] m_wline = '0;
  bit [LW-1:0] m_last = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rd = 0; m_wr = 0; m_req_done = 0; m_resp = 0; m_nb = 0;
      m_addr = '0; m_line = '0; m_wline = '0; m_last = '0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_rd) begin
      if (!m_req_done) begin
        if (bmem_ready) m_req_done = 1;
      end else if (bmem_rvalid) begin
        m_line[m_nb*BW +: BW] = bmem_rdata;
        m_nb++;
        if (m_nb == NB) begin
          m_last = m_line;
          m_rd   = 0;
          m_resp = 1;
        end
      end
    end else if (m_wr) begin
      if (bmem_ready) begin
        m_nb++;
        if (m_nb == NB) begin
          m_wr   = 0;
          m_resp = 1;
        end
      end
    end else if (dfp_read) begin
      m_rd = 1; m_req_done = 0; m_nb = 0;
      m_addr = dfp_addr & 32'hFFFF_FFE0;
    end else if (dfp_write) begin
      m_wr = 1; m_nb = 0;
      m_addr  = dfp_addr & 32'hFFFF_FFE0;
      m_wline = dfp_wdata;
    end
  end

  always @(negedge clk) begin : cmp
    bit          e_rd;
    bit          e_wr;
    bit [BW-1:0] e_wd;
    e_rd = m_rd && !m_req_done;
    e_wr = m_wr;
    e_wd = m_wr ? m_wline[m_nb*BW +: BW] : '0;
    chk("m_dfp_resp", dfp_resp, m_resp);
    chk("m_dfp_rdata", dfp_rdata, m_last);
    chk("m_bmem_read", bmem_read, e_rd);
    chk("m_bmem_write", bmem_write, e_wr);
    chk("m_bmem_wdata", bmem_wdata, e_wd);
    if (e_rd || e_wr) chk("m_bmem_addr", bmem_addr, m_addr);
    else if (!rst) chk("m_bmem_addr_rst", bmem_addr, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    dfp_read = 0; dfp_write = 0; bmem_ready = 0; bmem_rvalid = 0; bmem_rdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_resp"}, dfp_resp, 0);
    chk({tag, "_rdata"}, dfp_rdata, 0);
    chk({tag, "_addr"}, bmem_addr, 0);
    chk({tag, "_rw"}, {bmem_read, bmem_write}, 0);
    chk({tag, "_wdata"}, bmem_wdata, 0);
  endtask

  logic [LW-1:0] fill_line;
  logic [LW-1:0] wr_line;
  logic [LW-1:0] gap_line;
  logic [LW-1:0] pr_line;
  logic [LW-1:0] pw_line;
  logic [LW-1:0] post_line;

  initial begin
    int rp[7] = '{1, 0, 0, 1, 1, 0, 1};
    int wb[7] = '{0, 1, 1, 1, 2, 3, 3};
    int rv[7] = '{1, 0, 1, 0, 0, 1, 1};
    int rd_cnt, resp_cnt, bi;
    bit got;

    fill_line = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}};
    wr_line   = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    gap_line  = {64'h0F1E_2D3C_4B5A_6978, 64'hCAFE_BABE_0000_1111,
                 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    pr_line   = {64'h4444_0000_4444_0000, 64'h3333_0000_3333_0000,
                 64'h2222_0000_2222_0000, 64'h1111_0000_1111_0000};
    pw_line   = {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222,
                 64'h1111_0000_FFFF_EEEE, 64'hDDDD_CCCC_BBBB_AAAA};
    post_line = {64'hA5A5_A5A5_0000_0004, 64'hA5A5_A5A5_0000_0003,
                 64'hA5A5_A5A5_0000_0002, 64'hA5A5_A5A5_0000_0001};

    // Reset held with random inputs
    rst = 0;
    quiet();
    dfp_addr = '0; dfp_wdata = '0;
    for (int i = 0; i < 5; i++) begin
      dfp_read = 1'($urandom); dfp_write = 1'($urandom);
      bmem_ready = 1'($urandom); bmem_rvalid = 1'($urandom);
      dfp_addr = $urandom;
      dfp_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bmem_rdata = {$urandom, $urandom};
      step();
      chk_zero("rst_hold");
    end
    quiet();
    rst = 1;
    step();

    // Fill, memory always ready
    dfp_addr = 32'h1234_5678; dfp_read = 1; bmem_ready = 1;
    step();
    chk("fill_c1_read", bmem_read, 1);
    chk("fill_c1_addr", bmem_addr, 32'h1234_5660);
    dfp_addr = 32'hFFFF_FFFF;
    for (int b = 0; b < NB; b++) begin
      step();
      chk("fill_no_resp", dfp_resp, 0);
      chk("fill_read_low", bmem_read, 0);
      bmem_rvalid = 1;
      bmem_rdata  = fill_line[b*BW +: BW];
    end
    step();
    bmem_rvalid = 0; dfp_read = 0; bmem_ready = 0;
    chk("fill_c6_resp", dfp_resp, 1);
    chk("fill_c6_rdata", dfp_rdata, {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}});
    step();
    chk("fill_resp_pulse", dfp_resp, 0);
    chk("fill_rdata_hold", dfp_rdata, fill_line);

    // Writeback with backpressure
    dfp_write = 1; dfp_wdata = wr_line; dfp_addr = 32'h0000_ABCD;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("wr_write", bmem_write, 1);
      chk("wr_beat", bmem_wdata, wr_line[wb[k]*BW +: BW]);
      chk("wr_addr", bmem_addr, 32'h0000_ABC0);
      chk("wr_no_resp", dfp_resp, 0);
      bmem_ready = 1'(rp[k]);
      if (k == 0) dfp_wdata = '1;
    end
    step();
    chk("wr_resp", dfp_resp, 1);
    chk("wr_write_low", bmem_write, 0);
    chk("wr_rdata_kept", dfp_rdata, fill_line);
    dfp_write = 0; bmem_ready = 0;
    step();

    // Read with ready stall and rvalid gaps
    dfp_read = 1; dfp_addr = 32'h8000_005F;
    rd_cnt = 0; resp_cnt = 0; bi = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bmem_read) rd_cnt++;
      bmem_ready = (k == 3);
    end
    for (int k = 0; k < 7; k++) begin
      step();
      bmem_ready = 0;
      if (bmem_read) rd_cnt++;
      if (dfp_resp) resp_cnt++;
      bmem_rvalid = 1'(rv[k]);
      bmem_rdata  = rv[k] != 0 ? gap_line[bi*BW +: BW] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (rv[k] != 0) bi++;
    end
    step();
    bmem_rvalid = 0; dfp_read = 0;
    chk("gap_read_cycles", rd_cnt, 4);
    chk("gap_early_resp", resp_cnt, 0);
    chk("gap_resp", dfp_resp, 1);
    chk("gap_rdata", dfp_rdata, gap_line);
    step();
    chk("gap_resp_pulse", dfp_resp, 0);

    // Priority, then back-to-back write
    dfp_read = 1; dfp_write = 1; dfp_addr = 32'h0000_1000; dfp_wdata = pw_line; bmem_ready = 1;
    step();
    chk("pri_read_first", {bmem_read, bmem_write}, 2'b10);
    for (int b = 0; b < NB; b++) begin
      step();
      bmem_rvalid = 1;
      bmem_rdata  = pr_line[b*BW +: BW];
    end
    step();
    bmem_rvalid = 0; dfp_read = 0;
    chk("pri_rd_resp", dfp_resp, 1);
    chk("pri_rdata", dfp_rdata, pr_line);
    step();
    chk("b2b_dead_cycle", {bmem_write, dfp_resp}, 0);
    step();
    chk("b2b_wr_start", bmem_write, 1);
    chk("b2b_wr_beat0", bmem_wdata, pw_line[BW-1:0]);
    chk("b2b_wr_addr", bmem_addr, 32'h0000_1000);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (dfp_resp) got = 1;
    end
    chk("b2b_wr_resp", got, 1);
    chk("b2b_rdata_kept", dfp_rdata, pr_line);
    dfp_write = 0; bmem_ready = 0;
    step();

    // Reset in the middle of a fill, after two beats
    dfp_read = 1; dfp_addr = 32'h2000_0020; bmem_ready = 1;
    step();
    step(); bmem_rvalid = 1; bmem_rdata = 64'h1111_2222_3333_4444;
    step(); bmem_rdata = 64'h5555_6666_7777_8888;
    step();
    #2 rst = 0;
    #1 chk_zero("midrst");
    dfp_read = 0;
    @(posedge clk); #1;
    rst = 1;
    resp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (dfp_resp) resp_cnt++;
    end
    chk("midrst_no_resp", resp_cnt, 0);
    bmem_rvalid = 0;
    step();

    // Normal fill after the aborted one
    dfp_read = 1; dfp_addr = 32'h3000_0000; bmem_ready = 1;
    step();
    chk("post_addr", bmem_addr, 32'h3000_0000);
    for (int b = 0; b < NB; b++) begin
      step();
      bmem_rvalid = 1;
      bmem_rdata  = post_line[b*BW +: BW];
    end
    step();
    bmem_rvalid = 0; dfp_read = 0; bmem_ready = 0;
    chk("post_resp", dfp_resp, 1);
    chk("post_rdata", dfp_rdata, post_line);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Downstream neighbour of the pipelined cache.
- Converts the cache's 256-bit single-transfer dfp line interface into 4-beat, 64-bit bursts on the banked memory (bmem) port.
- Serves exactly one outstanding line read (fill) or line write (writeback) at a time.
- Returns the assembled line with a one-cycle dfp_resp pulse.

Parameters:
- LINE_W, 256, cache line width in bits
- BEAT_W, 64, memory beat width; BEATS = LINE_W/BEAT_W = 4, beat counter is log2(BEATS) bits

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- dfp_addr  in  32  line address from cache; bits [4:0] ignored
- dfp_read  in  1  line fill request, held until dfp_resp
- dfp_write  in  1  line writeback request, held until dfp_resp
- dfp_wdata  in  LINE_W  writeback line, valid with dfp_write
- dfp_rdata  out  LINE_W  filled line, valid when dfp_resp=1 on a read
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst base address {addr[31:5],5'b0}
- bmem_read  out  1  burst read request
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BEAT_W  current write beat
- bmem_ready  in  1  memory accepts read request / write beat this cycle
- bmem_rdata  in  BEAT_W  read beat
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, beat counter=0.
  - All outputs 0, including dfp_rdata, bmem_addr and bmem_wdata.
  - Takes effect immediately, independent of clk.
  - Reset mid-burst aborts the transfer with no dfp_resp. Late bmem_rvalid beats after reset release are ignored in IDLE.
- States: IDLE, RD_REQ, RD_DATA, WR, RESP.
- IDLE:
  - dfp_read=1 → latch aligned addr → RD_REQ.
  - Else dfp_write=1 → latch aligned addr and dfp_wdata → WR.
  - Read has priority if both are asserted; the write is not serviced that cycle.
- RD_REQ:
  - bmem_read=1, bmem_addr=latched addr.
  - Held until a cycle with bmem_ready=1, then → RD_DATA with counter=0.
- RD_DATA:
  - bmem_read=0.
  - Each cycle with bmem_rvalid=1, the line buffer slice [BEAT_W*cnt +: BEAT_W] ← bmem_rdata and cnt increments.
  - Beat 0 fills bits [63:0].
  - Gaps (rvalid=0) are allowed, with no timeout.
  - The 4th beat makes cnt wrap to 0 and → RESP.
- WR:
  - bmem_write=1, bmem_addr=latched addr, bmem_wdata=latched line slice [BEAT_W*cnt +: BEAT_W].
  - cnt advances only on bmem_ready=1.
  - Beat 3 accepted → cnt wraps to 0 → RESP.
- RESP:
  - dfp_resp=1 for exactly one cycle; bmem_read and bmem_write are 0 → IDLE.
  - dfp_rdata is driven from the line buffer, is stable in the RESP cycle, and holds until the next fill completes.
  - A writeback does not alter dfp_rdata.
- Requester contract: dfp_read/dfp_write are deasserted on the edge where dfp_resp is sampled. If still high in the following IDLE cycle, it is a new request.
- dfp_addr and dfp_wdata changes after the request is latched have no effect.
- bmem_rvalid outside RD_DATA is ignored. bmem_ready outside RD_REQ/WR is ignored.
- Minimum latency (request sampled in IDLE at cycle 0, memory always ready):
  - Read: bmem_read at cycle 1, beats at cycles 2–5, dfp_resp at cycle 6.
  - Write: beats at cycles 1–4, dfp_resp at cycle 5.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP, giving 1 dead cycle between transactions.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0. Assert rst=0 mid-RD_DATA after 2 beats → outputs 0 immediately, no dfp_resp, next read completes normally.
- Fill: dfp_addr=0x1234_5678, bmem_ready=1, beats 0x0..0,0x1..1,0x2..2,0x3..3 on cycles 2–5 → bmem_addr=0x1234_5660 at cycle 1, dfp_resp=1 only at cycle 6, dfp_rdata={0x3..3,0x2..2,0x1..1,0x0..0}.
- Writeback with backpressure: dfp_wdata=256'hDDDD..CCCC..BBBB..AAAA, bmem_ready toggling 1,0,0,1,1,0,1 → bmem_wdata sequence AAAA.., BBBB.., CCCC.., DDDD.., each beat held through stalls, dfp_resp one cycle after the 4th accepted beat.
- Read gaps and ready stall: bmem_ready=0 for 3 cycles in RD_REQ, rvalid pattern 1,0,1,0,0,1,1 → bmem_read held 4 cycles, correct line assembled, single dfp_resp.
- Priority and back-to-back: dfp_read=dfp_write=1 → read burst first. Requester then keeps dfp_write high → write starts in the IDLE cycle after RESP, and dfp_rdata is unchanged by the write.
